dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and a slow data memory.
- Replaces the single-cycle data memory port.
- Hits complete combinationally in the request cycle.
- Misses assert a stall toward the pipeline while an FSM performs writeback and line refill over a 128-bit handshake bus.

---
 rtl/dcache_ctrl_if.sv | 28 ++
 rtl/dcache_ctrl.sv | 156 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus bundle for the data cache controller.
// The slave modport is the cache's view: it serves CPU requests and drives
// the memory request lines. The master modport is the environment's view:
// the pipeline MEM stage together with the backing memory.
interface dcache_ctrl_if;
  logic         p1_req_i;
  logic         p1_we_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  p1_req_i, p1_we_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_we_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits finish combinationally in the request cycle; misses stall the pipeline
// while the FSM writes back a dirty victim and refills the line over a
// 128-bit request/ack bus.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
// TAG_W must equal 32 - INDEX_W - 4 so that line addresses are 32 bits wide.
module dcache_ctrl #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 23
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count_o,
  output logic [31:0]  miss_count_o
`endif
);

  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state;
  state_t state_next;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         word;
  logic [TAG_W-1:0]   line_tag;
  logic [127:0]       line_data;
  logic               hit;
  logic               idle_miss;
  logic               hit_store;
  logic               refill;
  logic               unused_addr_bits;

  assign req_tag   = bus.p1_addr_i[31 -: TAG_W];
  assign idx       = bus.p1_addr_i[4 +: INDEX_W];
  assign word      = bus.p1_addr_i[3:2];
  assign line_tag  = tag_mem[idx];
  assign line_data = data_mem[idx];

  // Byte offset bits are meaningless for word accesses.
  assign unused_addr_bits = ^bus.p1_addr_i[1:0];

  assign hit       = bus.p1_req_i & valid[idx] & (line_tag == req_tag);
  assign idle_miss = (state == IDLE) & bus.p1_req_i & ~hit;
  assign hit_store = (state == IDLE) & hit & bus.p1_we_i;
  assign refill    = (state == ALLOCATE) & bus.mem_ack_i;

  // State register; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: a dirty victim is written back before the refill.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (idle_miss) begin
          if (valid[idx] && dirty[idx]) state_next = WRITEBACK;
          else                          state_next = ALLOCATE;
        end
      end
      WRITEBACK: if (bus.mem_ack_i) state_next = ALLOCATE;
      ALLOCATE:  if (bus.mem_ack_i) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output logic; everything is forced quiet while reset is asserted.
  always_comb begin
    bus.p1_stall_o   = 1'b0;
    bus.p1_data_o    = 32'h0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = 32'h0;
    bus.mem_data_o   = 128'h0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          bus.p1_stall_o = bus.p1_req_i & ~hit;
          if (hit && !bus.p1_we_i) bus.p1_data_o = line_data[{word, 5'b0} +: 32];
        end
        WRITEBACK: begin
          bus.p1_stall_o   = 1'b1;
          bus.mem_enable_o = 1'b1;
          bus.mem_write_o  = 1'b1;
          bus.mem_addr_o   = {line_tag, idx, 4'b0};
          bus.mem_data_o   = line_data;
        end
        ALLOCATE: begin
          bus.p1_stall_o   = 1'b1;
          bus.mem_enable_o = 1'b1;
          bus.mem_addr_o   = {req_tag, idx, 4'b0};
        end
        default: ;
      endcase
    end
  end

  // Valid/dirty bits: refill installs a clean line, a store hit marks it dirty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (refill) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (hit_store) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard their contents.
  always_ff @(posedge clk_i) begin
    if (refill) begin
      tag_mem[idx]  <= req_tag;
      data_mem[idx] <= bus.mem_data_i;
    end else if (hit_store) begin
      data_mem[idx][{word, 5'b0} +: 32] <= bus.p1_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic missed;

  // Hit/miss counters; the retry hit that closes a miss is not a new hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_count_o  <= 32'h0;
      miss_count_o <= 32'h0;
      missed       <= 1'b0;
    end else begin
      if (idle_miss) begin
        miss_count_o <= miss_count_o + 32'h1;
        missed       <= 1'b1;
      end
      if (state == IDLE && hit) begin
        if (!missed) hit_count_o <= hit_count_o + 32'h1;
        missed <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus pushes expected CPU completions
// and expected memory transactions into queues, and independent monitors pop
// and compare them as the DUT presents them.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dcache_ctrl_if bus();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] data;
    int          stalls;
    string       name;
  } cpu_exp_t;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    string        name;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int checks = 0;
  int fails  = 0;
  int ack_delay = 3;

  logic [127:0] mem_lines [logic [31:0]];

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Backing memory: explicit lines where written, otherwise a fixed pattern
  // where word k of line a reads ({a[31:4],k,2'b00} ^ 32'h5A5A0000).
  function automatic logic [127:0] read_line(input logic [31:0] a);
    logic [127:0] l;
    if (mem_lines.exists(a)) return mem_lines[a];
    for (int k = 0; k < 4; k++)
      l[k*32 +: 32] = {a[31:4], 2'(k), 2'b00} ^ 32'h5A5A_0000;
    return l;
  endfunction

  task automatic expect_mem(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                            input string name);
    mem_exp_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.name = name;
    mem_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_data, input int exp_stalls, input string name);
    cpu_exp_t e;
    int n;
    logic done;
    @(posedge clk); #1;
    e.we = we; e.data = exp_data; e.stalls = exp_stalls; e.name = name;
    cpu_q.push_back(e);
    bus.p1_req_i  = 1'b1;
    bus.p1_we_i   = we;
    bus.p1_addr_i = addr;
    bus.p1_data_i = wdata;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (!bus.p1_stall_o) done = 1'b1;
      n++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s_timeout: actual=stalled required=complete within 100 cycles", name);
    end
    @(posedge clk); #1;
    bus.p1_req_i = 1'b0;
    bus.p1_we_i  = 1'b0;
  endtask

  // CPU monitor: counts stall cycles of each access and checks the completion.
  initial begin : cpu_monitor
    int stalls;
    cpu_exp_t e;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (rst || !bus.p1_req_i) begin
        stalls = 0;
      end else if (bus.p1_stall_o) begin
        stalls++;
      end else begin
        if (cpu_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL cpu_unexpected: actual=completion required=none");
        end else begin
          e = cpu_q.pop_front();
          check_output({e.name, "_stalls"}, 128'(stalls), 128'(e.stalls));
          if (!e.we) check_output({e.name, "_data"}, bus.p1_data_o, e.data);
        end
        stalls = 0;
      end
    end
  end

  // Memory model and memory-side monitor: acks each request after ack_delay
  // waiting cycles and checks every transaction against the expected queue.
  initial begin : mem_model
    int cnt;
    mem_exp_t e;
    logic         snap_wr;
    logic [31:0]  snap_addr;
    logic [127:0] snap_data;
    cnt = 0;
    snap_wr = 1'b0; snap_addr = 32'h0; snap_data = 128'h0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = 128'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (!bus.mem_enable_o) begin
        cnt = 0;
        check_output("idle_mem_write", bus.mem_write_o, 128'h0);
        check_output("idle_mem_addr", bus.mem_addr_o, 128'h0);
        check_output("idle_mem_data", bus.mem_data_o, 128'h0);
      end else begin
        cnt++;
        if (cnt == 1) begin
          snap_wr = bus.mem_write_o; snap_addr = bus.mem_addr_o; snap_data = bus.mem_data_o;
          if (mem_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL mem_unexpected: actual=wr%0d addr 0x%0h required=no transaction",
                     bus.mem_write_o, bus.mem_addr_o);
          end else begin
            e = mem_q.pop_front();
            check_output({e.name, "_write"}, bus.mem_write_o, e.wr);
            check_output({e.name, "_addr"}, bus.mem_addr_o, e.addr);
            if (e.wr) check_output({e.name, "_data"}, bus.mem_data_o, e.data);
          end
        end else begin
          check_output("mem_hold", {bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o},
                       {snap_wr, snap_addr, snap_data});
        end
        if (cnt > ack_delay) begin
          if (bus.mem_write_o) mem_lines[bus.mem_addr_o] = bus.mem_data_o;
          else                 bus.mem_data_i = read_line(bus.mem_addr_o);
          bus.mem_ack_i = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  // Main directed sequence.
  initial begin : stimulus
    rst = 1'b1;
    bus.p1_req_i  = 1'b0;
    bus.p1_we_i   = 1'b0;
    bus.p1_addr_i = 32'h0;
    bus.p1_data_i = 32'h0;
    mem_lines[32'h40] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

    // Reset quiets the outputs even with a request present.
    #12;
    bus.p1_req_i  = 1'b1;
    bus.p1_addr_i = 32'h40;
    #1;
    check_output("rst_stall", bus.p1_stall_o, 128'h0);
    check_output("rst_mem_enable", bus.mem_enable_o, 128'h0);
    check_output("rst_data", bus.p1_data_o, 128'h0);
    bus.p1_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("idle_stall", bus.p1_stall_o, 128'h0);
    check_output("idle_data", bus.p1_data_o, 128'h0);
    check_output("idle_mem_enable", bus.mem_enable_o, 128'h0);

    // Cold miss with refill, then store hit and load hit.
    expect_mem(1'b0, 32'h0000_0040, 128'h0, "refill_40");
    apply_stimulus(1'b0, 32'h0000_0040, 32'h0, 32'hAAAA_AAAA, 5, "load_40");
    apply_stimulus(1'b1, 32'h0000_0044, 32'h1234_5678, 32'h0, 0, "store_44");
    apply_stimulus(1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 0, "load_44");

    // Dirty conflict: writeback of the modified line, then refill.
    expect_mem(1'b1, 32'h0000_0040,
               {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'h1234_5678, 32'hAAAA_AAAA}, "wb_40");
    expect_mem(1'b0, 32'h0000_0240, 128'h0, "refill_240");
    apply_stimulus(1'b0, 32'h0000_0240, 32'h0, 32'h5A5A_0240, 9, "load_240");

    // Clean conflict: refill only; the written-back store comes back.
    expect_mem(1'b0, 32'h0000_0040, 128'h0, "refill_40b");
    apply_stimulus(1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 5, "load_44b");

    // Reset in the middle of a refill.
    expect_mem(1'b0, 32'h0000_1000, 128'h0, "abort_1000");
    @(posedge clk); #1;
    bus.p1_req_i  = 1'b1;
    bus.p1_we_i   = 1'b0;
    bus.p1_addr_i = 32'h0000_1000;
    @(negedge clk);
    check_output("abort_miss_stall", bus.p1_stall_o, 128'h1);
    @(negedge clk);
    check_output("abort_alloc_enable", bus.mem_enable_o, 128'h1);
    #2;
    rst = 1'b1;
    #1;
    check_output("abort_mem_enable", bus.mem_enable_o, 128'h0);
    check_output("abort_stall", bus.p1_stall_o, 128'h0);
    check_output("abort_mem_write", bus.mem_write_o, 128'h0);
    check_output("abort_data", bus.p1_data_o, 128'h0);
    @(negedge clk);
    bus.p1_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // After reset the same address misses again; then hit, hit, miss.
    expect_mem(1'b0, 32'h0000_1000, 128'h0, "refill_1000");
    apply_stimulus(1'b0, 32'h0000_1000, 32'h0, 32'h5A5A_1000, 5, "load_1000");
    apply_stimulus(1'b0, 32'h0000_1000, 32'h0, 32'h5A5A_1000, 0, "load_1000b");
    apply_stimulus(1'b0, 32'h0000_1008, 32'h0, 32'h5A5A_1008, 0, "load_1008");
    expect_mem(1'b0, 32'h0000_2010, 128'h0, "refill_2010");
    apply_stimulus(1'b0, 32'h0000_2010, 32'h0, 32'h5A5A_2010, 5, "load_2010");

    repeat (5) @(negedge clk);
    check_output("cpu_queue_left", 128'(cpu_q.size()), 128'h0);
    check_output("mem_queue_left", 128'(mem_q.size()), 128'h0);
`ifdef DCACHE_STATS_EN
    check_output("hit_count", hit_count, 128'd2);
    check_output("miss_count", miss_count, 128'd2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so a stuck run still reports.
  initial begin : watchdog
    #100000;
    fails++;
    $display("[TB] FAIL watchdog: actual=still running required=finished by 100000ns");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
